// File: rtl/cache_access_ctrl_if.sv
// rtl/cache_access_ctrl_if.sv - request, cache, memory and response signals of the cache access sequencer
interface cache_access_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int OFF_W  = 2
);
    logic                     req_valid;
    logic [ADDR_W-1:0]        req_addr;
    logic                     req_ready;
    logic [ADDR_W-1:0]        cache_addr;
    logic                     cache_rd;
    logic                     cache_hit;
    logic                     cache_fill;
    logic                     mem_rd;
    logic [ADDR_W-OFF_W-1:0]  mem_addr;
    logic                     mem_ack;
    logic                     resp_valid;
    logic                     resp_hit;

    modport master (
        input  req_valid, req_addr, cache_hit, mem_ack,
        output req_ready, cache_addr, cache_rd, cache_fill,
               mem_rd, mem_addr, resp_valid, resp_hit
    );

    modport slave (
        output req_valid, req_addr, cache_hit, mem_ack,
        input  req_ready, cache_addr, cache_rd, cache_fill,
               mem_rd, mem_addr, resp_valid, resp_hit
    );
endinterface

// File: rtl/cache_access_ctrl.sv
// rtl/cache_access_ctrl.sv - direct-mapped cache lookup / line-fill sequencer with hit and access statistics
// Optional memory-read timeout enabled by defining MEM_TIMEOUT_EN.
module cache_access_ctrl #(
    parameter int ADDR_W      = 15,
    parameter int OFF_W       = 2,
    parameter int NUM_ACCESS  = 8192,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    cache_access_ctrl_if.master      io_bus,
    output logic [31:0]              o_hit_count,
    output logic [31:0]              o_access_count,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_LOOKUP = 3'd2,
        S_MEMRD  = 3'd3,
        S_FILL   = 3'd4,
        S_RESP   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [31:0] LAST_CNT = 32'(NUM_ACCESS);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_cache_addr;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_access_count;
    logic                r_resp_hit;
    logic                w_start_go;
    logic                w_handshake;
    logic                w_last;
    logic                w_timeout;

    assign w_start_go  = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
    assign w_handshake = (r_state == S_ACCEPT) && io_bus.req_valid;
    assign w_last      = ((r_access_count + 32'd1) == LAST_CNT);

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == S_MEMRD) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // An ack landing on the last allowed cycle still completes the fill.
    assign w_timeout = (r_state == S_MEMRD) && (r_to_cnt == TO_LAST) && !io_bus.mem_ack;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_start_go) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign o_err            = 1'b0;
    assign w_unused_timeout = ^MEM_TIMEOUT;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_next = S_ACCEPT;
            S_ACCEPT:       if (io_bus.req_valid) w_next = S_LOOKUP;
            S_LOOKUP:       w_next = io_bus.cache_hit ? S_RESP : S_MEMRD;
            S_MEMRD: begin
                if (io_bus.mem_ack) begin
                    w_next = S_FILL;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_FILL:         w_next = S_RESP;
            S_RESP:         w_next = w_last ? S_DONE : S_ACCEPT;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cache_addr   <= '0;
            r_hit_count    <= '0;
            r_access_count <= '0;
            r_resp_hit     <= 1'b0;
        end else begin
            if (w_start_go) begin
                r_hit_count    <= '0;
                r_access_count <= '0;
            end
            if (w_handshake) begin
                r_cache_addr <= io_bus.req_addr;
            end
            if (r_state == S_LOOKUP) begin
                r_resp_hit <= io_bus.cache_hit;
                if (io_bus.cache_hit) begin
                    r_hit_count <= r_hit_count + 32'd1;
                end
            end
            if (r_state == S_RESP) begin
                r_access_count <= r_access_count + 32'd1;
            end
        end
    end

    always_comb begin
        io_bus.req_ready  = 1'b0;
        io_bus.cache_rd   = 1'b0;
        io_bus.cache_fill = 1'b0;
        io_bus.mem_rd     = 1'b0;
        io_bus.mem_addr   = '0;
        io_bus.resp_valid = 1'b0;
        io_bus.resp_hit   = 1'b0;
        o_busy            = 1'b1;
        o_done            = 1'b0;
        case (r_state)
            S_IDLE:   o_busy = 1'b0;
            S_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
            end
            S_ACCEPT: io_bus.req_ready = 1'b1;
            S_LOOKUP: io_bus.cache_rd  = 1'b1;
            S_MEMRD: begin
                io_bus.mem_rd   = 1'b1;
                io_bus.mem_addr = r_cache_addr[ADDR_W-1:OFF_W];
            end
            S_FILL:   io_bus.cache_fill = 1'b1;
            S_RESP: begin
                io_bus.resp_valid = 1'b1;
                io_bus.resp_hit   = r_resp_hit;
            end
            default:  o_busy = 1'b0;
        endcase
    end

    assign io_bus.cache_addr = r_cache_addr;
    assign o_hit_count       = r_hit_count;
    assign o_access_count    = r_access_count;

endmodule

// File: doc/cache_access_ctrl.md
Name: cache_access_ctrl

Overview:
- Sequencer for the direct-mapped cache / main-memory datapath (15-bit address = 3-bit tag, 10-bit index, 2-bit word offset; 128-bit memory line).
- Accepts word-address requests one at a time and drives cache lookup.
- On a miss, runs the main-memory line read and the cache line fill, then signals the response.
- Keeps hit and access statistics and raises done after a programmed number of accesses.

Parameters:
- ADDR_W, 15, request address width ({tag,index,word_offset}).
- OFF_W, 2, word-offset width; mem_addr is ADDR_W-OFF_W bits.
- NUM_ACCESS, 8192, accesses per run before done asserts.
- MEM_TIMEOUT, 64, cycles allowed for mem_ack (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled in IDLE or DONE only
- req_valid  in  1  request present
- req_addr  in  ADDR_W  requested word address
- req_ready  out  1  controller can accept a request
- cache_addr  out  ADDR_W  registered address driven to cache
- cache_rd  out  1  lookup strobe
- cache_hit  in  1  tag-match result for cache_addr, valid while cache_rd=1
- cache_fill  out  1  one-cycle line write strobe
- mem_rd  out  1  line read request, held until mem_ack
- mem_addr  out  ADDR_W-OFF_W  {tag,index} of line to fetch
- mem_ack  in  1  line data valid
- resp_valid  out  1  one-cycle pulse, cache data for cache_addr valid
- resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = filled miss
- hit_count  out  32  hits this run
- access_count  out  32  completed accesses this run
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE
- err  out  1  sticky memory timeout flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, counters 0, cache_addr=0, err=0. Reset mid-transaction abandons it; no fill or resp is issued.
- States: IDLE, ACCEPT, LOOKUP, MEMRD, FILL, RESP, DONE.
- IDLE/DONE: req_ready=0.
  - start=1 → ACCEPT; clears hit_count, access_count, err.
  - start=0 → hold. DONE holds done=1.
- ACCEPT: req_ready=1. On req_valid&req_ready → latch req_addr into cache_addr, go LOOKUP. Otherwise hold.
- LOOKUP: cache_rd=1 for one cycle.
  - cache_hit=1 → RESP with resp_hit=1; hit_count+1 on entry.
  - cache_hit=0 → MEMRD.
- MEMRD: mem_rd=1, mem_addr=cache_addr[ADDR_W-1:OFF_W]. Hold until mem_ack=1, then → FILL.
- FILL: cache_fill=1 for one cycle → RESP with resp_hit=0.
- RESP: resp_valid=1 for one cycle; access_count+1.
  - If the incremented value equals NUM_ACCESS → DONE.
  - Otherwise → ACCEPT.
- Latency, counted from the handshake edge: hit → resp_valid 2 cycles later; miss with mem_ack in the first MEMRD cycle → 4 cycles; each additional wait cycle adds 1.
- Throughput: at most one outstanding request; back-to-back hits give one response every 3 cycles.
- Boundaries:
  - mem_ack outside MEMRD is ignored.
  - req_valid outside ACCEPT is ignored; the requester must hold req_addr until the handshake.
  - start while busy is ignored.
  - access_count never exceeds NUM_ACCESS.
  - hit_count ≤ access_count at every RESP exit.
  - 32-bit counters do not wrap for NUM_ACCESS < 2^32.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in MEMRD.
  - If MEM_TIMEOUT cycles elapse without mem_ack: mem_rd drops, err sets (sticky until start or reset), state → DONE with no fill and no resp, access_count unchanged.
  - mem_ack arriving on the timeout cycle wins (normal FILL).
- Undefined: MEMRD waits indefinitely; err is tied 0; no timeout counter is synthesized.

Test Plan:
- Reset: rst_n low mid-MEMRD → all outputs 0 asynchronously, state IDLE; after release no cache_fill or resp_valid occurs.
- Hit path: start, req_addr=15'h1234, cache_hit=1 → cache_addr=15'h1234, resp_valid 2 cycles after handshake, resp_hit=1, hit_count=1, access_count=1, no mem_rd.
- Miss path: req_addr=15'h7FFC, cache_hit=0, mem_ack after 3 wait cycles → mem_addr=13'h1FFF held 4 cycles, then cache_fill 1 cycle, resp_valid next cycle with resp_hit=0, hit_count=0.
- Full run with NUM_ACCESS=8 and an alternating hit/miss pattern → done after the 8th resp_valid, access_count=8, hit_count=4, req_ready=0; extra req_valid is ignored.
- Restart: start in DONE → counters cleared, done=0, busy=1, ACCEPT next cycle.
- MEM_TIMEOUT_EN with MEM_TIMEOUT=4: miss with no mem_ack → mem_rd drops after 4 cycles, err=1, done=1, no resp_valid. Without the macro: mem_rd stays high for 100 cycles, err=0.
